// File: rtl/vram_pkg.sv
// Shared constants and FSM state type for VRAM CPU-port masters.
//   H_RES, V_RES : visible raster size; H_RES is also the row pitch in bytes
//   VRAM_AW      : byte address width of the 512K x 8 VRAM
//   fill_state_e : state encoding of the rectangle fill engine
//   row_addr()   : H_RES*y as a shift-add, no multiplier
package vram_pkg;

  localparam int unsigned H_RES   = 640;
  localparam int unsigned V_RES   = 480;
  localparam int unsigned VRAM_AW = 19;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StRd,
    StRdWait,
    StWr,
    StGap,
    StDone
  } fill_state_e;

  // 640*y = 512*y + 128*y; y <= 479 keeps the result inside 19 bits.
  function automatic logic [VRAM_AW-1:0] row_addr(input logic [9:0] y);
    logic [VRAM_AW-1:0] yw;
    yw = {{(VRAM_AW-10){1'b0}}, y};
    return (yw << 9) + (yw << 7);
  endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// Raster address generator for the rectangle fill engine.
//   clk, reset       : clock, asynchronous active-high reset
//   load             : start a new rectangle at (x0, y0)
//   step             : advance to the next pixel in raster order
//   x0, y0           : rectangle origin (held stable by the caller)
//   ew, eh           : clipped width/height (non-zero whenever step is used)
//   addr             : current byte address, H_RES*y + x
//   last_col         : current pixel is the last one of its row
//   last_pix         : current pixel is the last one of the rectangle
module vram_addr_gen
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [9:0]         x0,
  input  logic [9:0]         y0,
  input  logic [9:0]         ew,
  input  logic [9:0]         eh,
  output logic [VRAM_AW-1:0] addr,
  output logic               last_col,
  output logic               last_pix
);

  localparam logic [VRAM_AW-1:0] Pitch = VRAM_AW'(H_RES);

  logic [9:0]         col_q;
  logic [9:0]         row_q;
  logic [VRAM_AW-1:0] row_base_q;
  logic [VRAM_AW-1:0] addr_q;
  logic [VRAM_AW-1:0] x0_w;

  assign x0_w     = {{(VRAM_AW-10){1'b0}}, x0};
  assign last_col = (col_q == ew - 10'd1);
  assign last_pix = last_col && (row_q == eh - 10'd1);
  assign addr     = addr_q;

  // Each row restarts from the saved row base so no per-row subtraction is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else if (load) begin
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= row_addr(y0);
      addr_q     <= row_addr(y0) + x0_w;
    end else if (step) begin
      if (last_col) begin
        col_q      <= '0;
        row_q      <= row_q + 10'd1;
        row_base_q <= row_base_q + Pitch;
        addr_q     <= row_base_q + Pitch + x0_w;
      end else begin
        col_q  <= col_q + 10'd1;
        addr_q <= addr_q + VRAM_AW'(1);
      end
    end
  end

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle fill master for the vram_ctrl CPU port.
// Accepts one command (origin, size, colour), clips it to H_RES x V_RES and writes the colour
// into every covered pixel in raster order, one request every WR_GAP clocks.
//   clk, reset            : clock, asynchronous active-high reset
//   start / ready         : command handshake, accepted when both are high
//   x0, y0, width, height : rectangle, pixels
//   color, xor_mode       : fill colour; xor_mode selects dst ^= color
//   done                  : one-clock pulse after the last write
//   cpu_mem_wr/cpu_mem_rd : one-clock request pulses to vram_ctrl
//   cpu_addr, cpu_wr_data : request address (held through the gap) and write byte
//   cpu_rd_data           : read byte from vram_ctrl
// Build option: define RECT_FILL_XOR_EN to enable the read-modify-write XOR path; without it
// xor_mode is ignored and cpu_mem_rd is tied low.
module vram_rect_fill
  import vram_pkg::*;
#(
  parameter int unsigned WR_GAP = 3,
  parameter int unsigned RD_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               ready,
  input  logic [9:0]         x0,
  input  logic [9:0]         y0,
  input  logic [9:0]         width,
  input  logic [9:0]         height,
  input  logic [7:0]         color,
  input  logic               xor_mode,
  output logic               done,
  output logic               cpu_mem_wr,
  output logic               cpu_mem_rd,
  output logic [VRAM_AW-1:0] cpu_addr,
  output logic [7:0]         cpu_wr_data,
  input  logic [7:0]         cpu_rd_data
);

  // Counter reloads: the wait state is entered one clock after the request pulse.
  localparam logic [7:0] GapLoad = 8'(WR_GAP - 2);
`ifdef RECT_FILL_XOR_EN
  localparam logic [7:0] RdLoad  = 8'(RD_LAT - 2);
`endif

  fill_state_e state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [9:0]  x0_q, y0_q, width_q, height_q;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        accept;
  logic        load, step;
  logic        last_col, last_pix;
  logic        empty;
  logic [10:0] x_room, y_room;
  logic [9:0]  ew, eh;
  fill_state_e req_state;

`ifdef RECT_FILL_XOR_EN
  logic [7:0] color_q;
  logic       xor_q;
  assign req_state = xor_q ? StRd : StWr;
`else
  logic [8:0] unused_in;
  assign unused_in = {xor_mode, cpu_rd_data};
  assign req_state = StWr;
`endif

  // Clipping against the raster; x_room/y_room are only meaningful when the origin is inside.
  assign x_room = 11'(H_RES) - {1'b0, x0_q};
  assign y_room = 11'(V_RES) - {1'b0, y0_q};
  assign ew     = ({1'b0, width_q}  > x_room) ? x_room[9:0] : width_q;
  assign eh     = ({1'b0, height_q} > y_room) ? y_room[9:0] : height_q;
  assign empty  = (x0_q >= 10'(H_RES)) || (y0_q >= 10'(V_RES)) ||
                  (width_q == 10'd0) || (height_q == 10'd0);

  vram_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .x0       (x0_q),
    .y0       (y0_q),
    .ew       (ew),
    .eh       (eh),
    .addr     (cpu_addr),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    wr_data_d = wr_data_q;
    accept    = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          accept    = 1'b1;
          wr_data_d = color;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        if (empty) begin
          state_d = StDone;
        end else begin
          load    = 1'b1;
          state_d = req_state;
        end
      end
`ifdef RECT_FILL_XOR_EN
      StRd: begin
        wait_d  = RdLoad;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (wait_q == 8'd0) begin
          wr_data_d = cpu_rd_data ^ color_q;
          state_d   = StWr;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
`endif
      StWr: begin
        wait_d  = GapLoad;
        state_d = StGap;
      end
      StGap: begin
        if (wait_q == 8'd0) begin
          if (last_pix) begin
            state_d = StDone;
          end else begin
            // Address moves only here, so it is stable through the request and its gap.
            step    = 1'b1;
            state_d = req_state;
          end
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      wr_data_q <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      width_q   <= '0;
      height_q  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      wr_data_q <= wr_data_d;
      if (accept) begin
        x0_q     <= x0;
        y0_q     <= y0;
        width_q  <= width;
        height_q <= height;
      end
    end
  end

`ifdef RECT_FILL_XOR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_q <= '0;
      xor_q   <= 1'b0;
    end else if (accept) begin
      color_q <= color;
      xor_q   <= xor_mode;
    end
  end
  assign cpu_mem_rd = (state_q == StRd);
`else
  assign cpu_mem_rd = 1'b0;
`endif

  assign ready       = (state_q == StIdle);
  assign done        = (state_q == StDone);
  assign cpu_mem_wr  = (state_q == StWr);
  assign cpu_wr_data = wr_data_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
module tb_vram_rect_fill;

  localparam int WrGap = 3;
  localparam int HRes  = 640;
  localparam int VRes  = 480;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [9:0]  x0 = '0, y0 = '0, width = '0, height = '0;
  logic [7:0]  color = '0;
  logic        xor_mode = 1'b0;
  logic        done;
  logic        cpu_mem_wr, cpu_mem_rd;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wr_data;
  logic [7:0]  cpu_rd_data = 8'h5A;

  vram_rect_fill dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ready       (ready),
    .x0          (x0),
    .y0          (y0),
    .width       (width),
    .height      (height),
    .color       (color),
    .xor_mode    (xor_mode),
    .done        (done),
    .cpu_mem_wr  (cpu_mem_wr),
    .cpu_mem_rd  (cpu_mem_rd),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  tests = 0;
  int  fails = 0;
  int  wr_seen = 0;
  bit  idle_watch = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event seen at cycle %0d, expected none", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a request or a done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_mem_wr) begin
        wr_seen++;
        if (idle_watch) flag("wr_after_reset");
        else if (wq.size() == 0) flag("unexpected_wr");
        else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", int'(cpu_addr), e.addr);
          check("wr_data", int'(cpu_wr_data), e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (cpu_mem_rd) flag("rd_in_plain_build");
      if (done) begin
        if (idle_watch) flag("done_after_reset");
        else if (dq.size() == 0) flag("unexpected_done");
        else begin
          check("done_cycle", cyc, dq.pop_front());
          check("writes_left_at_done", wq.size(), 0);
        end
      end
    end
  end

  // Reference: clip the rectangle and enumerate pixels in raster order.
  task automatic model(input int x, input int y, input int w, input int h, input int c,
                       input int s);
    int ew, eh, n;
    ew = 0;
    eh = 0;
    n  = 0;
    if (x < HRes && y < VRes) begin
      ew = (w < HRes - x) ? w : HRes - x;
      eh = (h < VRes - y) ? h : VRes - y;
    end
    for (int r = 0; r < eh; r++) begin
      for (int k = 0; k < ew; k++) begin
        wr_t e;
        e.addr = HRes * (y + r) + x + k;
        e.data = c;
        e.cyc  = s + 2 + WrGap * n;
        wq.push_back(e);
        n++;
      end
    end
    dq.push_back(s + 2 + WrGap * n);
  endtask

  task automatic issue(input int x, input int y, input int w, input int h, input int c,
                       input int xm);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) flag("ready_timeout");
    x0       = 10'(x);
    y0       = 10'(y);
    width    = 10'(w);
    height   = 10'(h);
    color    = 8'(c);
`ifdef RECT_FILL_XOR_EN
    xor_mode = 1'b0;
`else
    xor_mode = xm[0];
`endif
    start    = 1'b1;
    model(x, y, w, h, c, cyc);
    @(negedge clk);
    start    = 1'b0;
    x0       = 10'($urandom);
    color    = 8'($urandom);
    check("ready_low_after_accept", int'(ready), 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (dq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (dq.size() != 0) begin
      flag("done_timeout");
      dq.delete();
      wq.delete();
    end
  endtask

  task automatic fill(input int x, input int y, input int w, input int h, input int c,
                      input int xm);
    issue(x, y, w, h, c, xm);
    wait_done();
    @(negedge clk);
    check("ready_after_done", int'(ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, n;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_wr", int'(cpu_mem_wr), 0);
    check("rst_rd", int'(cpu_mem_rd), 0);
    check("rst_addr", int'(cpu_addr), 0);
    check("rst_wr_data", int'(cpu_wr_data), 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    fill(10, 2, 3, 2, 'hA5, 1);
    fill(638, 479, 5, 5, 'h3C, 0);
    fill(100, 100, 0, 4, 'h11, 0);
    fill(640, 10, 4, 4, 'h22, 0);
    fill(10, 480, 4, 4, 'h33, 0);
    fill(0, 0, 1, 1, 'hFF, 1);
    fill(639, 0, 1, 3, 'h77, 0);

    // Random commands, biased toward the right and bottom edges
    for (int i = 0; i < 30; i++) begin
      int x, y;
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(630, 645)) : int'($urandom_range(0, 639));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(470, 485)) : int'($urandom_range(0, 479));
      fill(x, y, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    end

    // Reset in the middle of a fill, after four writes
    base = wr_seen;
    issue(20, 30, 10, 1, 'h5C, 0);
    n = 0;
    while (wr_seen < base + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("writes_before_reset", wr_seen - base, 4);
    reset = 1'b1;
    idle_watch = 1'b1;
    wq.delete();
    dq.delete();
    #1;
    check("midrst_wr", int'(cpu_mem_wr), 0);
    check("midrst_addr", int'(cpu_addr), 0);
    check("midrst_wr_data", int'(cpu_wr_data), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("ready_after_reset", int'(ready), 1);
    idle_watch = 1'b0;

    // Engine still works after the abandoned command
    fill(5, 7, 2, 2, 'h81, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
